// File: rtl/ps_stage_sync.sv
// Program-store lookup stage: merges packets with a stored {next_dest, flags, opc} word.
// Define PS_WR_BYPASS_EN to forward a same-cycle store write into the lookup.
module ps_stage_sync #(
  parameter int GEN_W  = 11,
  parameter int DEST_W = 7,
  parameter int DATA_W = 34,
  parameter int FLAG_W = 4,
  parameter int OPC_W  = 6,
  parameter logic [OPC_W-1:0] ABSORB_OPC = '1,
  parameter int CNT_W  = 16
) (
  input  logic                    CP,
  input  logic                    MR_N,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [GEN_W+DEST_W+DATA_W-1:0] in_packet,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [GEN_W+DEST_W+FLAG_W+OPC_W+DATA_W-1:0] out_packet,
  output logic                    del,
  input  logic                    pw_en,
  input  logic [DEST_W-1:0]       pw_addr,
  input  logic [DEST_W+FLAG_W+OPC_W-1:0] pw_data,
  output logic [CNT_W-1:0]        absorb_cnt
);

  localparam int WORD_W = DEST_W + FLAG_W + OPC_W;
  localparam int DEPTH  = 1 << DEST_W;

  logic [WORD_W-1:0] store [DEPTH];

  logic [GEN_W-1:0]  gen;
  logic [DEST_W-1:0] dest;
  logic [DATA_W-1:0] data;
  logic [WORD_W-1:0] word;
  logic [OPC_W-1:0]  opc;
  logic              accept;
  logic              absorb;

  assign {gen, dest, data} = in_packet;

  always_comb begin
    word = store[dest];
`ifdef PS_WR_BYPASS_EN
    if (pw_en && (pw_addr == dest)) begin
      word = pw_data;
    end
`endif
  end

  assign opc      = word[OPC_W-1:0];
  assign in_ready = !out_valid || out_ready;
  // Reset masks acceptance so nothing is loaded or absorbed.
  assign accept   = MR_N && in_valid && in_ready;
  assign absorb   = accept && (opc == ABSORB_OPC);

  always_ff @(posedge CP) begin
    if (pw_en) begin
      store[pw_addr] <= pw_data;
    end
  end

  always_ff @(posedge CP) begin
    if (!MR_N) begin
      out_valid  <= 1'b0;
      out_packet <= '0;
      del        <= 1'b0;
      absorb_cnt <= '0;
    end else begin
      del <= absorb;
      if (absorb && !(&absorb_cnt)) begin
        absorb_cnt <= absorb_cnt + CNT_W'(1);
      end
      if (accept && !absorb) begin
        out_valid  <= 1'b1;
        out_packet <= {gen, word, data};
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule
